mem_nport_pipelined: RTL and testbench

- Parametrised successor to the three-way unified data memory: NUM_PORTS independent load/store channels into one byte-addressed, 64-bit-line array.
- Every request is tagged; completion (tag + load data) returns a fixed LATENCY cycles later.
- Adds misalignment/range rejection, per-port tag counters and a deterministic same-cycle store priority across ports.
- Sits below the LSQ/cache layer as the simulation memory model for the superscalar core.

---
 rtl/mem_nport_pipelined_pkg.sv | 59 +++++
 rtl/mem_nport_pipelined_if.sv | 27 ++
 rtl/mem_nport_pipelined_port_pipe.sv | 38 +++
 rtl/mem_nport_pipelined.sv | 81 ++++++++
 tb/tb_mem_nport_pipelined.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_nport_pipelined_pkg.sv
// Shared types and helpers for the multi-port pipelined data memory model.
// Covers bus command and size encodings, request/completion records and alignment helpers.
package mem_nport_pipelined_pkg;

    localparam int XLEN            = 32;
    localparam int MEM_64BIT_LINES = 64;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef struct packed {
        BUS_COMMAND      command;
        logic [XLEN-1:0] addr;
        logic [63:0]     data;
        MEM_SIZE         size;
    } MEM_REQ;

    // Tag field is sized for the widest tag any instance is expected to use.
    typedef struct packed {
        logic [7:0]  tag;
        logic [63:0] data;
    } MEM_CPL;

    function automatic logic [3:0] mem_size_bytes(MEM_SIZE size);
        return 4'd1 << size;
    endfunction

    function automatic logic mem_aligned(logic [2:0] offset, MEM_SIZE size);
        case (size)
            HALF:    return offset[0] == 1'b0;
            WORD:    return offset[1:0] == 2'b00;
            DOUBLE:  return offset == 3'b000;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] mem_byte_mask(MEM_SIZE size);
        return 8'((9'd1 << mem_size_bytes(size)) - 9'd1);
    endfunction

    function automatic logic [63:0] mem_data_mask(MEM_SIZE size);
        logic [7:0]  bm;
        logic [63:0] mask;
        bm = mem_byte_mask(size);
        for (int b = 0; b < 8; b++) mask[b*8 +: 8] = {8{bm[b]}};
        return mask;
    endfunction

endpackage

// File: rtl/mem_nport_pipelined_if.sv
// Request/response bundle between the core's load/store channels and the memory model.
interface mem_nport_pipelined_if
    import mem_nport_pipelined_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int TAG_W     = 4
) ();

    BUS_COMMAND        proc2mem_command  [NUM_PORTS];
    logic [XLEN-1:0]   proc2mem_addr     [NUM_PORTS];
    logic [63:0]       proc2mem_data     [NUM_PORTS];
    MEM_SIZE           proc2mem_size     [NUM_PORTS];
    logic [TAG_W-1:0]  mem2proc_response [NUM_PORTS];
    logic [63:0]       mem2proc_data     [NUM_PORTS];
    logic [TAG_W-1:0]  mem2proc_tag      [NUM_PORTS];

    modport master (
        output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        input  mem2proc_response, mem2proc_data, mem2proc_tag
    );

    modport slave (
        input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        output mem2proc_response, mem2proc_data, mem2proc_tag
    );

endinterface

// File: rtl/mem_nport_pipelined_port_pipe.sv
// Per-port tag counter and fixed-latency completion pipeline of {tag, data}.
module mem_port_pipe #(
    parameter int LATENCY = 1,
    parameter int TAG_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             accept,
    input  logic [63:0]      load_data,
    output logic [TAG_W-1:0] next_tag,
    output logic [TAG_W-1:0] cpl_tag,
    output logic [63:0]      cpl_data
);

    logic [TAG_W-1:0] tag_p  [LATENCY];
    logic [63:0]      data_p [LATENCY];

    // Tag stages are control: flushed on reset so in-flight requests never complete.
    always_ff @(posedge clock) begin
        if (reset) begin
            next_tag <= TAG_W'(1);
            for (int i = 0; i < LATENCY; i++) tag_p[i] <= '0;
        end else begin
            if (accept) next_tag <= (next_tag == '1) ? TAG_W'(1) : next_tag + TAG_W'(1);
            tag_p[0] <= accept ? next_tag : '0;
            for (int i = 1; i < LATENCY; i++) tag_p[i] <= tag_p[i-1];
        end
    end

    always_ff @(posedge clock) begin
        data_p[0] <= load_data;
        for (int i = 1; i < LATENCY; i++) data_p[i] <= data_p[i-1];
    end

    assign cpl_tag  = tag_p[LATENCY-1];
    assign cpl_data = (cpl_tag != '0) ? data_p[LATENCY-1] : '0;

endmodule

// File: rtl/mem_nport_pipelined.sv
// NUM_PORTS-channel byte-addressed memory over 64-bit lines with tagged, fixed-latency completions.
module mem_nport_pipelined
    import mem_nport_pipelined_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int MEM_LINES = MEM_64BIT_LINES,
    parameter int LATENCY   = 1,
    parameter int TAG_W     = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_nport_pipelined_if.slave  bus
);

    localparam int              LINE_W    = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(MEM_LINES * 8);

    logic [63:0]                      mem [MEM_LINES];
    MEM_REQ                           req      [NUM_PORTS];
    logic [NUM_PORTS-1:0]             accept;
    logic [7:0]                       byte_en  [NUM_PORTS];
    logic [LINE_W-1:0]                line_idx [NUM_PORTS];
    logic [63:0]                      wdata    [NUM_PORTS];
    logic [63:0]                      rdata    [NUM_PORTS];
    logic [NUM_PORTS-1:0][TAG_W-1:0]  next_tag;
    logic [NUM_PORTS-1:0][TAG_W-1:0]  cpl_tag;
    logic [NUM_PORTS-1:0][63:0]       cpl_data;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            req[p].command = bus.proc2mem_command[p];
            req[p].addr    = bus.proc2mem_addr[p];
            req[p].data    = bus.proc2mem_data[p];
            req[p].size    = bus.proc2mem_size[p];

            accept[p]   = !reset && (req[p].command != BUS_NONE)
                          && mem_aligned(req[p].addr[2:0], req[p].size)
                          && (req[p].addr < MEM_BYTES);
            line_idx[p] = req[p].addr[LINE_W+2:3];
            byte_en[p]  = mem_byte_mask(req[p].size) << req[p].addr[2:0];
            wdata[p]    = req[p].data << {req[p].addr[2:0], 3'b000};

            // Reads see the array before this edge's stores from any port.
            rdata[p] = '0;
            if (accept[p] && req[p].command == BUS_LOAD)
                rdata[p] = (mem[line_idx[p]] >> {req[p].addr[2:0], 3'b000})
                           & mem_data_mask(req[p].size);

            bus.mem2proc_response[p] = accept[p] ? next_tag[p] : '0;
            bus.mem2proc_tag[p]      = cpl_tag[p];
            bus.mem2proc_data[p]     = cpl_data[p];
        end
    end

    // Ascending port order: a higher-indexed port's byte write overrides a lower one's.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (accept[p] && req[p].command == BUS_STORE) begin
                for (int b = 0; b < 8; b++) begin
                    if (byte_en[p][b]) mem[line_idx[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        mem_port_pipe #(
            .LATENCY (LATENCY),
            .TAG_W   (TAG_W)
        ) u_pipe (
            .clock     (clock),
            .reset     (reset),
            .accept    (accept[p]),
            .load_data (rdata[p]),
            .next_tag  (next_tag[p]),
            .cpl_tag   (cpl_tag[p]),
            .cpl_data  (cpl_data[p])
        );
    end

endmodule

// File: tb/tb_mem_nport_pipelined.sv
// Bench for mem_nport_pipelined: a LATENCY=1 and a LATENCY=3 instance driven by directed vectors.
module tb_mem_nport_pipelined;
    import mem_nport_pipelined_pkg::*;

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   lat [2] = '{1, 3};
    exp_t exp_q [6][$];

    mem_nport_pipelined_if #(.NUM_PORTS(3), .TAG_W(4)) ifa ();
    mem_nport_pipelined_if #(.NUM_PORTS(3), .TAG_W(4)) ifb ();

    mem_nport_pipelined #(.NUM_PORTS(3), .MEM_LINES(64), .LATENCY(1), .TAG_W(4)) dut_a (
        .clock (clk),
        .reset (rst),
        .bus   (ifa)
    );

    mem_nport_pipelined #(.NUM_PORTS(3), .MEM_LINES(64), .LATENCY(3), .TAG_W(4)) dut_b (
        .clock (clk),
        .reset (rst),
        .bus   (ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] get_rsp(input int d, input int p);
        return (d == 0) ? ifa.mem2proc_response[p] : ifb.mem2proc_response[p];
    endfunction

    function automatic logic [3:0] get_tag(input int d, input int p);
        return (d == 0) ? ifa.mem2proc_tag[p] : ifb.mem2proc_tag[p];
    endfunction

    function automatic logic [63:0] get_data(input int d, input int p);
        return (d == 0) ? ifa.mem2proc_data[p] : ifb.mem2proc_data[p];
    endfunction

    task automatic idle_all();
        for (int p = 0; p < 3; p++) begin
            ifa.proc2mem_command[p] = BUS_NONE;
            ifa.proc2mem_addr[p]    = '0;
            ifa.proc2mem_data[p]    = '0;
            ifa.proc2mem_size[p]    = BYTE;
            ifb.proc2mem_command[p] = BUS_NONE;
            ifb.proc2mem_addr[p]    = '0;
            ifb.proc2mem_data[p]    = '0;
            ifb.proc2mem_size[p]    = BYTE;
        end
    endtask

    task automatic set_req(input int d, input int p, input BUS_COMMAND c,
                           input logic [31:0] a, input logic [63:0] wd, input MEM_SIZE s);
        if (d == 0) begin
            ifa.proc2mem_command[p] = c;
            ifa.proc2mem_addr[p]    = a;
            ifa.proc2mem_data[p]    = wd;
            ifa.proc2mem_size[p]    = s;
        end else begin
            ifb.proc2mem_command[p] = c;
            ifb.proc2mem_addr[p]    = a;
            ifb.proc2mem_data[p]    = wd;
            ifb.proc2mem_size[p]    = s;
        end
    endtask

    // Checks the same-cycle response; an accepted request queues its completion.
    task automatic expect_req(input int d, input int p, input logic [3:0] rsp, input logic [63:0] ld);
        logic [3:0] got;
        got = get_rsp(d, p);
        checks++;
        if (got !== rsp) begin
            errors++;
            $display("FAIL rsp dut%0d port%0d cyc%0d: got %0d want %0d", d, p, cyc, got, rsp);
        end
        if (rsp != 4'd0) exp_q[d*3+p].push_back('{rsp, ld, cyc + lat[d]});
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_all();
    endtask

    // Completion monitor: each due entry must appear on its exact cycle, nothing else may appear.
    always @(negedge clk) begin
        logic [3:0]  t;
        logic [63:0] dt;
        exp_t        e;
        int          k;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 3; p++) begin
                k  = d*3 + p;
                t  = get_tag(d, p);
                dt = get_data(d, p);
                if (exp_q[k].size() > 0 && exp_q[k][0].due == cyc) begin
                    e = exp_q[k].pop_front();
                    checks++;
                    if (t !== e.tag || dt !== e.data) begin
                        errors++;
                        $display("FAIL cpl dut%0d port%0d cyc%0d: got tag %0d data %h want tag %0d data %h",
                                 d, p, cyc, t, dt, e.tag, e.data);
                    end
                end else if (t != 4'd0 || dt != 64'd0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected cpl dut%0d port%0d cyc%0d: got tag %0d data %h want none",
                             d, p, cyc, t, dt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of stimulus want finish");
        $fatal(1);
    end

    initial begin
        idle_all();
        rst = 1'b1;
        @(posedge clk); #1;
        // Request during reset: must be refused.
        set_req(0, 0, BUS_STORE, 32'd0, 64'hFFFF, WORD);
        #1;
        expect_req(0, 0, 4'd0, 64'd0);
        tick();
        chk("rst_tag_a0",  {60'd0, ifa.mem2proc_tag[0]}, 64'd0);
        chk("rst_data_b2", ifb.mem2proc_data[2], 64'd0);
        rst = 1'b0;

        // Basic stores then load.
        set_req(0, 0, BUS_STORE, 32'd0, 64'h11, WORD);
        set_req(0, 1, BUS_STORE, 32'd4, 64'h22, WORD);
        set_req(0, 2, BUS_STORE, 32'd8, 64'h33, WORD);
        #1;
        expect_req(0, 0, 4'd1, 64'd0);
        expect_req(0, 1, 4'd1, 64'd0);
        expect_req(0, 2, 4'd1, 64'd0);
        tick();
        set_req(0, 1, BUS_LOAD, 32'd4, 64'd0, WORD);
        #1;
        expect_req(0, 1, 4'd2, 64'h22);
        tick();

        // Same-cycle store priority.
        set_req(0, 0, BUS_STORE, 32'd12, 64'hAAAAAAAA, WORD);
        set_req(0, 1, BUS_STORE, 32'd12, 64'hBBBB, HALF);
        set_req(0, 2, BUS_STORE, 32'd12, 64'hCC, BYTE);
        #1;
        expect_req(0, 0, 4'd2, 64'd0);
        expect_req(0, 1, 4'd3, 64'd0);
        expect_req(0, 2, 4'd2, 64'd0);
        tick();
        set_req(0, 0, BUS_LOAD, 32'd12, 64'd0, WORD);
        set_req(0, 2, BUS_LOAD, 32'd8, 64'd0, DOUBLE);
        #1;
        expect_req(0, 0, 4'd3, 64'hAAAABBCC);
        expect_req(0, 2, 4'd3, 64'hAAAABBCC_00000033);
        tick();

        // Read-before-write.
        set_req(0, 2, BUS_STORE, 32'd56, 64'h9, DOUBLE);
        #1;
        expect_req(0, 2, 4'd4, 64'd0);
        tick();
        set_req(0, 0, BUS_STORE, 32'd56, 64'h5, DOUBLE);
        set_req(0, 1, BUS_LOAD, 32'd56, 64'd0, DOUBLE);
        #1;
        expect_req(0, 0, 4'd4, 64'd0);
        expect_req(0, 1, 4'd4, 64'h9);
        tick();
        set_req(0, 2, BUS_LOAD, 32'd56, 64'd0, DOUBLE);
        #1;
        expect_req(0, 2, 4'd5, 64'h5);
        tick();

        // Rejection: misaligned and out of range.
        set_req(0, 0, BUS_STORE, 32'd40, 64'h0123456789ABCDEF, DOUBLE);
        #1;
        expect_req(0, 0, 4'd5, 64'd0);
        tick();
        set_req(0, 0, BUS_LOAD, 32'd45, 64'd0, HALF);
        set_req(0, 1, BUS_STORE, 32'd42, 64'hDEADBEEF, WORD);
        set_req(0, 2, BUS_LOAD, 32'd512, 64'd0, DOUBLE);
        #1;
        expect_req(0, 0, 4'd0, 64'd0);
        expect_req(0, 1, 4'd0, 64'd0);
        expect_req(0, 2, 4'd0, 64'd0);
        tick();
        set_req(0, 0, BUS_LOAD, 32'd40, 64'd0, DOUBLE);
        set_req(0, 1, BUS_LOAD, 32'd44, 64'd0, WORD);
        set_req(0, 2, BUS_LOAD, 32'd46, 64'd0, HALF);
        #1;
        expect_req(0, 0, 4'd6, 64'h0123456789ABCDEF);
        expect_req(0, 1, 4'd5, 64'h01234567);
        expect_req(0, 2, 4'd6, 64'h0123);
        tick();

        // LATENCY=3 back-to-back loads with tag wrap.
        set_req(1, 1, BUS_STORE, 32'd0, 64'h77, WORD);
        #1;
        expect_req(1, 1, 4'd1, 64'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            set_req(1, 0, BUS_LOAD, 32'd0, 64'd0, WORD);
            #1;
            expect_req(1, 0, 4'((i % 15) + 1), 64'h77);
            tick();
        end
        repeat (4) tick();

        // Reset with two loads in flight.
        set_req(1, 0, BUS_LOAD, 32'd0, 64'd0, WORD);
        #1;
        expect_req(1, 0, 4'd6, 64'h77);
        tick();
        set_req(1, 0, BUS_LOAD, 32'd0, 64'd0, WORD);
        #1;
        expect_req(1, 0, 4'd7, 64'h77);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) exp_q[k].delete();
        set_req(1, 0, BUS_STORE, 32'd0, 64'hFF, WORD);
        #1;
        expect_req(1, 0, 4'd0, 64'd0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        set_req(1, 0, BUS_LOAD, 32'd0, 64'd0, WORD);
        #1;
        expect_req(1, 0, 4'd1, 64'h77);
        tick();
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
